// File: rtl/sram_b_pkg.sv
// Shared definitions for the banked 1W/1R SRAM: controller state encoding
// and the helpers that derive the bank-array geometry from the parameters.
// Pure compile-time content; no ports, no latency, no flow control.
package sram_b_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_REPLAY = 2'd2
    } state_e;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/unisim_sram_b_bank.sv
// One BRAM primitive: 2^ABITS x DW, port 0 write-only (bit mask), port 1 read-only.
// Read latency 1 (registered output, holds while re1_i is low); writes take effect at the edge.
// No backpressure: both ports accept every cycle they are enabled.
// Ports: clk_i/rst_ni, we0_i/a0_i/d0_i/wem0_i (write), re1_i/a1_i/q1_o (read).
module unisim_sram_b_bank #(
    parameter int ABITS = 14,
    parameter int DW    = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we0_i,
    input  logic [ABITS-1:0] a0_i,
    input  logic [DW-1:0]    d0_i,
    input  logic [DW-1:0]    wem0_i,
    input  logic             re1_i,
    input  logic [ABITS-1:0] a1_i,
    output logic [DW-1:0]    q1_o
);

    logic [DW-1:0] mem_q [2**ABITS];
    logic [DW-1:0] q_q;

    // Storage array is not reset; contents are cleared by the controller's sweep.
    always_ff @(posedge clk_i) begin
        if (we0_i) begin
            for (int b = 0; b < DW; b++) begin
                if (wem0_i[b]) begin
                    mem_q[a0_i][b] <= d0_i[b];
                end
            end
        end
    end

    // Output latch resets so the read data bus starts at zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else if (re1_i) begin
            q_q <= mem_q[a1_i];
        end
    end

    assign q1_o = q_q;

endmodule

// File: rtl/unisim_sram_b_banked.sv
// Banked 1W/1R SRAM with bit masks, post-reset zero sweep and same-address read replay.
// Read latency RD_LATENCY (1 or 2) cycles; a colliding read returns one cycle later.
// RDY0/RDY1 drop during the init sweep and for the single replay cycle; CE while not ready is ignored.
// Ports: CLK/RSTN; write CE0/A0/D0/WE0/WEM0/RDY0; read CE1/A1/RDY1/Q1/Q1_VALID; INIT_DONE.
module unisim_sram_b_banked
    import sram_b_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 17,
    parameter int BANK_ABITS  = 14,
    parameter int BANK_DWIDTH = 1,
    parameter int RD_LATENCY  = 1,
    parameter int INIT_ZERO   = 1
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  CE0,
    input  logic [ADDR_WIDTH-1:0] A0,
    input  logic [DATA_WIDTH-1:0] D0,
    input  logic                  WE0,
    input  logic [DATA_WIDTH-1:0] WEM0,
    output logic                  RDY0,
    input  logic                  CE1,
    input  logic [ADDR_WIDTH-1:0] A1,
    output logic                  RDY1,
    output logic [DATA_WIDTH-1:0] Q1,
    output logic                  Q1_VALID,
    output logic                  INIT_DONE
);

    localparam int NV = 2 ** (ADDR_WIDTH - BANK_ABITS);
    localparam int NH = ceil_div(DATA_WIDTH, BANK_DWIDTH);
    localparam int PW = NH * BANK_DWIDTH;
    localparam int SW = (NV > 1) ? clog2(NV) : 1;
    localparam state_e RST_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_RUN;

    state_e                state_q, state_d;
    logic                  rdy_q;
    logic                  init_done_q;
    logic [BANK_ABITS-1:0] init_cnt_q;
    logic [ADDR_WIDTH-1:0] replay_addr_q;
    logic                  vld1_q;
    logic [SW-1:0]         sel1_q;

    logic                  wr_acc, rd_acc, collide, in_init, in_replay, rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [SW-1:0]         wr_sel, rd_sel;
    logic [BANK_ABITS-1:0] wr_local, rd_local;
    logic [PW-1:0]         wdat, wmask, mux_row;
    logic [NV-1:0]         bank_we, bank_re;
    logic [NV-1:0][PW-1:0] rowq;
    logic                  unused_pad;

    // rdy_q mirrors (state_q == ST_RUN) but is held low through reset.
    assign wr_acc    = CE0 & WE0 & rdy_q;
    assign rd_acc    = CE1 & rdy_q;
    assign collide   = wr_acc & rd_acc & (A0 == A1);
    assign in_init   = (state_q == ST_INIT);
    assign in_replay = (state_q == ST_REPLAY);
    // A colliding read is withheld from the primitive and re-issued next cycle.
    assign rd_en     = (rd_acc & ~collide) | in_replay;
    assign rd_addr   = in_replay ? replay_addr_q : A1;

    if (NV > 1) begin : g_sel
        assign wr_sel = A0[ADDR_WIDTH-1:BANK_ABITS];
        assign rd_sel = rd_addr[ADDR_WIDTH-1:BANK_ABITS];
    end else begin : g_nosel
        assign wr_sel = '0;
        assign rd_sel = '0;
    end

    // During the sweep every vertical bank is written with zeros at the counter address.
    assign wr_local = in_init ? init_cnt_q : A0[BANK_ABITS-1:0];
    assign rd_local = rd_addr[BANK_ABITS-1:0];
    assign wdat     = in_init ? '0 : PW'(D0);
    assign wmask    = in_init ? {PW{1'b1}} : PW'(WEM0);

    always_comb begin
        bank_we = '0;
        bank_re = '0;
        for (int v = 0; v < NV; v++) begin
            bank_we[v] = in_init | (wr_acc & (wr_sel == SW'(v)));
            bank_re[v] = rd_en & (rd_sel == SW'(v));
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:   if (init_cnt_q == '1) state_d = ST_RUN;
            ST_RUN:    if (collide) state_d = ST_REPLAY;
            ST_REPLAY: state_d = ST_RUN;
            default:   state_d = RST_STATE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q       <= RST_STATE;
            rdy_q         <= 1'b0;
            init_done_q   <= 1'b0;
            init_cnt_q    <= '0;
            replay_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= (state_d == ST_RUN);
            init_done_q <= (state_d != ST_INIT);
            if (in_init) begin
                init_cnt_q <= init_cnt_q + 1'b1;
            end
            if (collide) begin
                replay_addr_q <= A1;
            end
        end
    end

    // Bank select travels with the primitive's read; only updated on a read so Q1 holds.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            vld1_q <= 1'b0;
            sel1_q <= '0;
        end else begin
            vld1_q <= rd_en;
            if (rd_en) begin
                sel1_q <= rd_sel;
            end
        end
    end

    for (genvar v = 0; v < NV; v++) begin : g_row
        for (genvar h = 0; h < NH; h++) begin : g_col
            unisim_sram_b_bank #(
                .ABITS (BANK_ABITS),
                .DW    (BANK_DWIDTH)
            ) u_bank (
                .clk_i  (CLK),
                .rst_ni (RSTN),
                .we0_i  (bank_we[v]),
                .a0_i   (wr_local),
                .d0_i   (wdat[h*BANK_DWIDTH +: BANK_DWIDTH]),
                .wem0_i (wmask[h*BANK_DWIDTH +: BANK_DWIDTH]),
                .re1_i  (bank_re[v]),
                .a1_i   (rd_local),
                .q1_o   (rowq[v][h*BANK_DWIDTH +: BANK_DWIDTH])
            );
        end
    end

    assign mux_row    = rowq[sel1_q];
    assign unused_pad = ^mux_row;

    if (RD_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] q2_q;
        logic                  vld2_q;
        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                q2_q   <= '0;
                vld2_q <= 1'b0;
            end else begin
                vld2_q <= vld1_q;
                if (vld1_q) begin
                    q2_q <= mux_row[DATA_WIDTH-1:0];
                end
            end
        end
        assign Q1       = q2_q;
        assign Q1_VALID = vld2_q;
    end else begin : g_lat1
        assign Q1       = mux_row[DATA_WIDTH-1:0];
        assign Q1_VALID = vld1_q;
    end

    assign RDY0      = rdy_q;
    assign RDY1      = rdy_q;
    assign INIT_DONE = init_done_q;

    // A primitive must never see a write and a read to the same cell in one cycle.
    always @(posedge CLK) begin
        if (RSTN) begin
            assert (!((|(bank_we & bank_re)) && (wr_local == rd_local)));
        end
    end

endmodule

// File: doc/unisim_sram_b_banked.md
# unisim_sram_b_banked

Parametrised 1-write/1-read banked SRAM for accelerator private local memories. It tiles `DATA_WIDTH` × 2^`ADDR_WIDTH` storage from dual-port BRAM primitives, with bit-granular write masks. It adds three behaviours: a selectable read latency, a post-reset zero-initialisation sweep, and hardware resolution of same-address write/read collisions by automatic read replay, instead of a simulation abort. It replaces the fixed-geometry generated `sram_b` wrappers at every PLM instance that needs deterministic collision behaviour or a cleared memory.

## Interface
- `DATA_WIDTH`, 8: word width in bits.
- `ADDR_WIDTH`, 17: word address width.
- `BANK_ABITS`, 14: address bits per bank primitive; vertical bank count NV = 2^(`ADDR_WIDTH`−`BANK_ABITS`).
- `BANK_DWIDTH`, 1: data bits per bank primitive; horizontal bank count NH = ceil(`DATA_WIDTH`/`BANK_DWIDTH`). Bits of the last column beyond `DATA_WIDTH` are tied 0.
- `RD_LATENCY`, 1: 1 or 2 cycles; 2 adds an output register after the bank-select mux.
- `INIT_ZERO`, 1: 1 means zero-fill all storage after reset.
- `CLK` in 1: single clock, rising edge.
- `RSTN` in 1: reset, asynchronous, active-low.
- `CE0` in 1: write-port enable.
- `A0` in `ADDR_WIDTH`: write address.
- `D0` in `DATA_WIDTH`: write data.
- `WE0` in 1: write enable.
- `WEM0` in `DATA_WIDTH`: per-bit write mask; 1 means write the bit.
- `RDY0` out 1: write port accepts when high.
- `CE1` in 1: read request.
- `A1` in `ADDR_WIDTH`: read address.
- `RDY1` out 1: read port accepts when high.
- `Q1` out `DATA_WIDTH`: read data.
- `Q1_VALID` out 1: single-cycle strobe marking valid `Q1`.
- `INIT_DONE` out 1: high once the init sweep is complete.

## Operation
- Address split: `A[ADDR_WIDTH-1:BANK_ABITS]` selects the vertical bank; `A[BANK_ABITS-1:0]` is the bank-local address. Port 0 of each primitive is write-only; port 1 is read-only.
- Write accepted when `CE0 & WE0 & RDY0`. Only bits with `WEM0`=1 change.
- Read accepted when `CE1 & RDY1`. The vertical-bank select is registered alongside, following the pipeline to the output mux.
- FSM states:
  - INIT (entered at reset when `INIT_ZERO`=1): a counter of `BANK_ABITS` bits drives port 0 of all banks with D=0, full mask. When the counter reaches 2^`BANK_ABITS`−1 the FSM goes to RUN.
  - RUN: normal operation.
  - REPLAY: one cycle that re-issues a deferred read.
  - With `INIT_ZERO`=0, reset enters RUN directly.
- Collision: an accepted write and an accepted read in the same cycle with `A0`==`A1`:
  - The write completes.
  - Port 1 of the bank is not enabled that cycle.
  - `A1` is captured and the FSM goes to REPLAY.
  - In REPLAY, port 1 reads the captured address, which returns the new data. `RDY0`=`RDY1`=0. The FSM then returns to RUN.
- No collision: a write and a read to the same bank at different addresses proceed concurrently.
- Ready signals:
  - `RDY0` = (state==RUN).
  - `RDY1` = (state==RUN).
  - A `CE` asserted while its `RDY` is low is ignored, with no side effect.
- `INIT_DONE` = (state != INIT), registered.

## Timing
- Reset values: `Q1`=0, `Q1_VALID`=0, `RDY0`=`RDY1`=0, `INIT_DONE`=0; the FSM is in INIT, or in RUN when `INIT_ZERO`=0. With `INIT_ZERO`=0, `RDY0`/`RDY1`/`INIT_DONE` go to 1 in the first cycle after `RSTN` deasserts.
- Init duration: exactly 2^`BANK_ABITS` cycles after reset release, then `INIT_DONE`=1 and `RDY`=1 on the next cycle.
- Read latency: read accepted at cycle t gives `Q1`/`Q1_VALID` at t+`RD_LATENCY`. A colliding read gives them at t+1+`RD_LATENCY`.
- `Q1` holds its last value when `Q1_VALID`=0.
- Write effects are visible to a read accepted in cycle t+1 or later.
- Back-to-back reads: one per cycle, fully pipelined.
- Reset mid-operation (`RSTN` low in any state): the FSM returns immediately to INIT, the pipeline valids clear, a pending replay is dropped, and the init sweep restarts from address 0.

## Structure
- Package `sram_b_pkg`: FSM state encoding (INIT, RUN, REPLAY) and the NV/NH derivation functions (clog2, ceil-div).
- Sub-module `unisim_sram_b_bank`: one BRAM primitive wrapper, 2^`BANK_ABITS` × `BANK_DWIDTH`, with port 0 write and port 1 read. It is instantiated NV×NH times under generate.
- Top level owns the FSM, init counter, replay register, select pipeline and output mux.
- Simulation-only assertion: no same-address port-0/port-1 bank access ever reaches a primitive.

## Test plan
- Reset/init, `ADDR_WIDTH`=8, `BANK_ABITS`=6, `INIT_ZERO`=1: release `RSTN`. `INIT_DONE` must rise after 64 cycles; a read of every address returns 0x00.
- Masked write: write 0xFF to 0x2A, then write 0x00 with `WEM0`=0x0F, then read 0x2A. `Q1` must be 0xF0 with `Q1_VALID` at t+1 (`RD_LATENCY`=1) or t+2 (`RD_LATENCY`=2).
- Collision: write 0xA5 to 0x13 and read 0x13 in the same cycle t. `RDY` must be low at t+1 and `Q1`=0xA5 at t+1+`RD_LATENCY`. A `CE1` presented at t+1 must be ignored.
- Cross-bank streaming: write 0x11 to 0x05 while reading 0x45 (different bank) every cycle for 16 cycles. There must be no stall, and 16 `Q1_VALID` strobes must arrive at the configured latency.
- Reset mid-init: pull `RSTN` low at cycle 30 of the sweep, then release. `INIT_DONE` must rise 64 cycles after the second release, and all addresses must read 0.
- Non-power-of-two width, `DATA_WIDTH`=12, `BANK_DWIDTH`=8: write 0xABC and read it back. `Q1` must be 0xABC.
